// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared RV32I constants for the fetch stage and register file
package if_fetch_unit_pkg;
    localparam int RF_ADD_SIZE = 5;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush (flush wins over push) and occupancy count
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign count = cnt;
    assign rdata = mem[rd_ptr];
    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage with credit-limited requests, response buffer and redirect squash
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          XLEN = if_fetch_unit_pkg::XLEN,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_if_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_pc_plus4
);
    localparam int CW = $clog2(BUF_DEPTH + MAX_OUTSTANDING) + 1;
    localparam int FW = $clog2(BUF_DEPTH) + 1;
    localparam int QW = $clog2(MAX_OUTSTANDING) + 1;
    logic [XLEN-1:0] fetch_pc, pcq_head;
    logic [CW-1:0] live, drop, live_dec, live_nxt, drop_nxt;
    logic started, accept, keep, discard, pop;
    logic [FW-1:0] buf_count;
    logic [QW-1:0] pcq_count;
    logic buf_full, buf_empty, pcq_full, pcq_empty;
    logic [2*XLEN-1:0] buf_head;
    assign o_imem_req = started && !i_redirect
        && (CW'(buf_count) + live < CW'(BUF_DEPTH))
        && (live + drop < CW'(MAX_OUTSTANDING));
    assign o_imem_addr = fetch_pc;
    assign accept = o_imem_req && i_imem_gnt;
    assign keep = i_imem_rvalid && drop == '0;
    assign discard = i_imem_rvalid && drop != '0;
    assign pop = o_id_valid && !i_if_stall;
    assign o_id_valid = !buf_empty;
    assign o_id_instr = o_id_valid ? buf_head[XLEN-1:0] : XLEN'(NOP_INSTR);
    assign o_id_pc = o_id_valid ? buf_head[2*XLEN-1:XLEN] : '0;
    assign o_id_pc_plus4 = o_id_pc + XLEN'(4);
    // same-cycle response settles against the old totals before a redirect moves live into drop
    always_comb begin
        live_dec = live + CW'(accept) - CW'(keep);
        live_nxt = i_redirect ? '0 : live_dec;
        drop_nxt = i_redirect ? drop - CW'(discard) + live_dec : drop - CW'(discard);
    end
    // fetch PC and in-flight accounting; started holds req low until the first cycle out of reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            started <= 1'b0;
            fetch_pc <= XLEN'(RESET_PC);
            live <= '0;
            drop <= '0;
        end else begin
            started <= 1'b1;
            fetch_pc <= i_redirect ? i_redirect_pc : accept ? fetch_pc + XLEN'(4) : fetch_pc;
            live <= live_nxt;
            drop <= drop_nxt;
        end
    end
    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (keep),
        .pop   (pop),
        .flush (i_redirect),
        .wdata ({pcq_head, i_imem_rdata}),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (accept),
        .pop   (i_imem_rvalid),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );
    a_rvalid_tracked: assert property (@(posedge i_clk) disable iff (i_rst)
        i_imem_rvalid |-> (live + drop) != '0);
    a_addr_aligned: assert property (@(posedge i_clk) disable iff (i_rst)
        o_imem_addr[1:0] == 2'b00);
    a_pcq_in_sync: assert property (@(posedge i_clk) disable iff (i_rst)
        CW'(pcq_count) == live + drop);
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(keep && buf_full && !pop) && !(accept && pcq_full) && !(i_imem_rvalid && pcq_empty));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle tables plus randomized run against an in-order fetch model
module tb_if_fetch_unit;
    logic i_clk = 1'b0, i_rst = 1'b1;
    logic o_imem_req, i_imem_gnt, i_imem_rvalid, i_if_stall, i_redirect, o_id_valid;
    logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc, o_id_instr, o_id_pc, o_id_pc_plus4;
    always #5 i_clk = ~i_clk;
    if_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_if_stall    (i_if_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_id_valid    (o_id_valid),
        .o_id_instr    (o_id_instr),
        .o_id_pc       (o_id_pc),
        .o_id_pc_plus4 (o_id_pc_plus4)
    );
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit start; int lat; logic st; logic rd; logic [31:0] rpc;
        logic ereq; logic [31:0] eaddr; logic evalid; logic [31:0] epc;
    } row_t;
    mreq_t mq[$];
    row_t tbl[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, lat_cur = 1;
    bit rand_gnt = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic row(input bit start, input int lat, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc);
        tbl.push_back('{start, lat, st, rd, rpc, ereq, eaddr, evalid, epc});
    endtask
    task automatic apply(input logic st, input logic rd, input logic [31:0] rpc);
        i_if_stall = st;
        i_redirect = rd;
        i_redirect_pc = rpc;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = 32'h0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata = mq[0].addr ^ SALT;
            end
        end
        i_imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask
    task automatic commit();
        if (i_imem_rvalid) void'(mq.pop_front());
        if (o_imem_req && i_imem_gnt) mq.push_back('{o_imem_addr, cyc + lat_cur});
        cyc++;
    endtask
    task automatic do_reset(input int lat);
        i_rst = 1'b1;
        {i_if_stall, i_redirect, i_imem_gnt, i_imem_rvalid} = 4'b0;
        i_redirect_pc = 32'h0;
        i_imem_rdata = 32'h0;
        mq.delete();
        lat_cur = lat;
        rand_gnt = 0;
        #1;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_id_valid), 32'd0);
        check("rst_instr", o_id_instr, NOP);
        check("rst_pc", o_id_pc, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask
    task automatic wait_req();
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            #1;
            if (o_imem_req) return;
            cyc++;
        end
        check("req_timeout", 32'(o_imem_req), 32'd1);
    endtask
    initial begin
        logic st, rd;
        logic [31:0] rpc, exp_id, exp_fetch;
        int consumed;
        // start-up stream and stall/fill with 1-cycle memory
        row(1, 1, 0, 0, 0, 1, 32'h00, 0, 0);
        row(0, 1, 0, 0, 0, 1, 32'h04, 0, 0);
        row(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00);
        row(0, 1, 0, 0, 0, 1, 32'h0c, 1, 32'h04);
        row(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h08);
        row(0, 1, 1, 0, 0, 1, 32'h14, 1, 32'h08);
        row(0, 1, 1, 0, 0, 0, 32'h00, 1, 32'h08);
        row(0, 1, 0, 0, 0, 0, 32'h00, 1, 32'h08);
        row(0, 1, 0, 0, 0, 1, 32'h18, 1, 32'h0c);
        row(0, 1, 0, 0, 0, 1, 32'h1c, 1, 32'h10);
        row(0, 1, 0, 0, 0, 1, 32'h20, 1, 32'h14);
        // redirect with two requests in flight, 3-cycle memory
        row(1, 3, 0, 0, 0, 1, 32'h000, 0, 0);
        row(0, 3, 0, 0, 0, 1, 32'h004, 0, 0);
        row(0, 3, 0, 1, 32'h100, 0, 0, 0, 0);
        row(0, 3, 0, 0, 0, 0, 32'h000, 0, 0);
        row(0, 3, 0, 0, 0, 1, 32'h100, 0, 0);
        row(0, 3, 0, 0, 0, 1, 32'h104, 0, 0);
        row(0, 3, 0, 0, 0, 0, 32'h000, 0, 0);
        row(0, 3, 0, 0, 0, 0, 32'h000, 0, 0);
        row(0, 3, 0, 0, 0, 1, 32'h108, 1, 32'h100);
        row(0, 3, 0, 0, 0, 1, 32'h10c, 1, 32'h104);
        // redirect + stall + rvalid in the same cycle
        row(1, 1, 0, 0, 0, 1, 32'h000, 0, 0);
        row(0, 1, 0, 0, 0, 1, 32'h004, 0, 0);
        row(0, 1, 1, 1, 32'h200, 0, 0, 1, 32'h000);
        row(0, 1, 0, 0, 0, 1, 32'h200, 0, 0);
        row(0, 1, 0, 0, 0, 1, 32'h204, 0, 0);
        row(0, 1, 0, 0, 0, 1, 32'h208, 1, 32'h200);
        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].start) begin
                do_reset(tbl[r].lat);
                wait_req();
            end else @(negedge i_clk);
            apply(tbl[r].st, tbl[r].rd, tbl[r].rpc);
            #1;
            check($sformatf("row%0d_req", r), 32'(o_imem_req), 32'(tbl[r].ereq));
            if (tbl[r].ereq) check($sformatf("row%0d_addr", r), o_imem_addr, tbl[r].eaddr);
            check($sformatf("row%0d_valid", r), 32'(o_id_valid), 32'(tbl[r].evalid));
            if (tbl[r].evalid) begin
                check($sformatf("row%0d_pc", r), o_id_pc, tbl[r].epc);
                check($sformatf("row%0d_instr", r), o_id_instr, tbl[r].epc ^ SALT);
                check($sformatf("row%0d_pc4", r), o_id_pc_plus4, tbl[r].epc + 32'd4);
            end else check($sformatf("row%0d_nop", r), o_id_instr, NOP);
            commit();
        end
        // randomized: 50% gnt, 3-cycle memory, random stalls and redirects
        do_reset(3);
        rand_gnt = 1;
        wait_req();
        exp_id = 32'h0;
        exp_fetch = 32'h0;
        consumed = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i > 0) @(negedge i_clk);
            st = $urandom_range(0, 9) < 3;
            rd = $urandom_range(0, 19) == 0;
            rpc = 32'($urandom_range(0, 1023)) << 2;
            apply(st, rd, rpc);
            #1;
            check("addr_align", {30'b0, o_imem_addr[1:0]}, 32'h0);
            check("outstanding_le2", 32'(mq.size() <= 2), 32'd1);
            if (o_imem_req) check("fetch_addr", o_imem_addr, exp_fetch);
            if (rd) check("req_on_redirect", 32'(o_imem_req), 32'd0);
            if (o_id_valid) begin
                check("id_pc", o_id_pc, exp_id);
                check("id_instr", o_id_instr, exp_id ^ SALT);
                check("id_pc4", o_id_pc_plus4, exp_id + 32'd4);
            end else check("id_nop", o_id_instr, NOP);
            if (rd) begin
                exp_id = rpc;
                exp_fetch = rpc;
            end else begin
                if (o_id_valid && !st) begin
                    exp_id += 32'd4;
                    consumed++;
                end
                if (o_imem_req && i_imem_gnt) exp_fetch += 32'd4;
            end
            commit();
        end
        check("liveness", 32'(consumed > 50), 32'd1);
        // asynchronous reset mid-burst, between clock edges
        @(negedge i_clk);
        #3;
        do_reset(1);
        wait_req();
        check("post_rst_addr", o_imem_addr, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
